// File: rtl/game_ctrl.sv
// Game state controller: collision detection, IDLE/PLAY/DYING/OVER FSM, BCD score and high score.
// Optional build macro GAME_CTRL_GODMODE_EN disables pipe collisions (ground/ceiling only).
module game_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_en,
  input  logic        btn_flap,
  input  logic [11:0] bird_y,
  input  logic [11:0] pipe1_x,
  input  logic [11:0] pipe1_gap_y,
  input  logic [11:0] pipe2_x,
  input  logic [11:0] pipe2_gap_y,
  input  logic        score_pulse,
  output logic        game_active,
  output logic        game_over,
  output logic [1:0]  state,
  output logic        flap_pulse,
  output logic        collision,
  output logic [11:0] score_bcd,
  output logic [11:0] hi_score_bcd
);

  localparam int unsigned SCREEN_H     = 768;
  localparam int unsigned BIRD_X       = 300;
  localparam int unsigned BIRD_SIZE    = 32;
  localparam int unsigned PIPE_W       = 80;
  localparam int unsigned HALF_GAP     = 110;
  localparam int unsigned DEATH_FRAMES = 60;
  localparam int unsigned CNT_W        = 6;
  localparam int unsigned AW           = 13;

`ifdef GAME_CTRL_GODMODE_EN
  localparam logic PIPE_HIT_EN = 1'b0;
`else
  localparam logic PIPE_HIT_EN = 1'b1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic               sync1, sync2, sync3;
  logic               flap_edge_c;
  logic [CNT_W-1:0]   death_cnt, cnt_nxt;
  logic [11:0]        score_nxt, hi_nxt;
  logic               flap_nxt, coll_nxt;
  logic               ground_c, ceil_c, pipe_c, hit_c;
  logic [AW-1:0]      bird_top, bird_bot;

  // Pipe hit: horizontal overlap and bird outside the gap (edge contact allowed)
  function automatic logic pipe_hit(input logic [11:0] px, input logic [11:0] gy,
                                    input logic [AW-1:0] top, input logic [AW-1:0] bot);
    logic [AW-1:0] x, g, gap_top, gap_bot;
    logic          h_ovl;
    x       = {1'b0, px};
    g       = {1'b0, gy};
    gap_top = (g < AW'(HALF_GAP)) ? '0 : g - AW'(HALF_GAP);
    gap_bot = g + AW'(HALF_GAP);
    h_ovl   = (x < AW'(BIRD_X + BIRD_SIZE)) && ((x + AW'(PIPE_W)) > AW'(BIRD_X));
    return h_ovl && ((top < gap_top) || (bot > gap_bot));
  endfunction

  // Saturating 3-digit BCD increment
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] h, t, o;
    {h, t, o} = v;
    if (v == 12'h999) return v;
    if (o == 4'd9) begin
      o = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      o = o + 4'd1;
    end
    return {h, t, o};
  endfunction

  assign flap_edge_c = sync2 & ~sync3;
  assign bird_top    = {1'b0, bird_y};
  assign bird_bot    = bird_top + AW'(BIRD_SIZE);
  assign ground_c    = bird_bot >= AW'(SCREEN_H);
  assign ceil_c      = bird_y[11];
  assign pipe_c      = pipe_hit(pipe1_x, pipe1_gap_y, bird_top, bird_bot) |
                       pipe_hit(pipe2_x, pipe2_gap_y, bird_top, bird_bot);
  assign hit_c       = ground_c | ceil_c | (PIPE_HIT_EN & pipe_c);
  assign state       = state_q;

  // State register plus registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      death_cnt    <= '0;
      score_bcd    <= '0;
      hi_score_bcd <= '0;
      flap_pulse   <= 1'b0;
      collision    <= 1'b0;
      game_active  <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      sync1        <= btn_flap;
      sync2        <= sync1;
      sync3        <= sync2;
      death_cnt    <= cnt_nxt;
      score_bcd    <= score_nxt;
      hi_score_bcd <= hi_nxt;
      flap_pulse   <= flap_nxt;
      collision    <= coll_nxt;
      game_active  <= (state_nxt == S_PLAY);
      game_over    <= (state_nxt == S_OVER);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt = state_q;
    score_nxt = score_bcd;
    hi_nxt    = hi_score_bcd;
    cnt_nxt   = death_cnt;
    flap_nxt  = 1'b0;
    coll_nxt  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flap_edge_c) begin
          state_nxt = S_PLAY;
          score_nxt = '0;
          flap_nxt  = 1'b1;
        end
      end
      S_PLAY: begin
        if (flap_edge_c) flap_nxt = 1'b1;
        if (score_pulse) score_nxt = bcd_inc(score_bcd);
        if (frame_en && hit_c) begin
          coll_nxt  = 1'b1;
          state_nxt = S_DYING;
          cnt_nxt   = '0;
        end
      end
      S_DYING: begin
        if (frame_en) begin
          if (death_cnt == CNT_W'(DEATH_FRAMES - 1)) begin
            state_nxt = S_OVER;
            // Packed BCD digits compare correctly as a plain binary value
            if (score_bcd > hi_score_bcd) hi_nxt = score_bcd;
          end else begin
            cnt_nxt = death_cnt + CNT_W'(1);
          end
        end
      end
      S_OVER: begin
        if (flap_edge_c) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl (honours GAME_CTRL_GODMODE_EN if defined).
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_en;
  logic        btn_flap;
  logic [11:0] bird_y;
  logic [11:0] pipe1_x, pipe1_gap_y, pipe2_x, pipe2_gap_y;
  logic        score_pulse;
  logic        game_active, game_over, flap_pulse, collision;
  logic [1:0]  state;
  logic [11:0] score_bcd, hi_score_bcd;

  int n_assert = 0;
  int n_fail   = 0;

  game_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_en     (frame_en),
    .btn_flap     (btn_flap),
    .bird_y       (bird_y),
    .pipe1_x      (pipe1_x),
    .pipe1_gap_y  (pipe1_gap_y),
    .pipe2_x      (pipe2_x),
    .pipe2_gap_y  (pipe2_gap_y),
    .score_pulse  (score_pulse),
    .game_active  (game_active),
    .game_over    (game_over),
    .state        (state),
    .flap_pulse   (flap_pulse),
    .collision    (collision),
    .score_bcd    (score_bcd),
    .hi_score_bcd (hi_score_bcd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    frame_en = 1'b1;
    tick();
    frame_en = 1'b0;
  endtask

  initial begin
    logic [11:0] exp_score;
    rst_n = 1'b0; frame_en = 1'b0; btn_flap = 1'b0; score_pulse = 1'b0;
    bird_y = 12'd300;
    pipe1_x = 12'd1000; pipe1_gap_y = 12'd384;
    pipe2_x = 12'd1000; pipe2_gap_y = 12'd384;
    tick(); tick();

    // Reset state
    chk("rst_state", 12'(state), 12'd0);
    chk("rst_active", 12'(game_active), 12'd0);
    chk("rst_over", 12'(game_over), 12'd0);
    chk("rst_flap", 12'(flap_pulse), 12'd0);
    chk("rst_score", score_bcd, 12'h000);
    chk("rst_hi", hi_score_bcd, 12'h000);
    rst_n = 1'b1;
    tick();

    // Game 1 start: three clocks of latency through the synchroniser
    btn_flap = 1'b1;
    tick();
    chk("start_e1_state", 12'(state), 12'd0);
    tick();
    chk("start_e2_state", 12'(state), 12'd0);
    chk("start_e2_flap", 12'(flap_pulse), 12'd0);
    tick();
    chk("start_state", 12'(state), 12'd1);
    chk("start_active", 12'(game_active), 12'd1);
    chk("start_flap", 12'(flap_pulse), 12'd1);
    chk("start_score", score_bcd, 12'h000);
    tick();
    chk("start_flap_end", 12'(flap_pulse), 12'd0);

    // Score counting with decimal carries and saturation
    score_pulse = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      case (i)
        9:    chk("score_9", score_bcd, 12'h009);
        10:   chk("score_10", score_bcd, 12'h010);
        99:   chk("score_99", score_bcd, 12'h099);
        100:  chk("score_100", score_bcd, 12'h100);
        999:  chk("score_999", score_bcd, 12'h999);
        1000: chk("score_sat", score_bcd, 12'h999);
        default: ;
      endcase
    end
    score_pulse = 1'b0;

    // Pipe overlap, bird inside the gap, including exact gap edges
    pipe1_x = 12'd250;
    bird_y = 12'd300;
    frame();
    chk("gap_in_coll", 12'(collision), 12'd0);
    chk("gap_in_state", 12'(state), 12'd1);
    bird_y = 12'd274;
    frame();
    chk("gap_top_edge", 12'(collision), 12'd0);
    bird_y = 12'd462;
    frame();
    chk("gap_bot_edge", 12'(collision), 12'd0);
    chk("gap_edge_state", 12'(state), 12'd1);

    // Bird above gap: no evaluation without frame_en
    bird_y = 12'd250;
    tick();
    chk("no_frame_state", 12'(state), 12'd1);
    frame();
`ifdef GAME_CTRL_GODMODE_EN
    chk("pipe_god_coll", 12'(collision), 12'd0);
    chk("pipe_god_state", 12'(state), 12'd1);
    bird_y = 12'd736;
    frame();
`endif
    chk("hit_coll", 12'(collision), 12'd1);
    chk("hit_state", 12'(state), 12'd2);
    chk("hit_active", 12'(game_active), 12'd0);
    tick();
    chk("hit_coll_end", 12'(collision), 12'd0);
    bird_y = 12'd300;
    pipe1_x = 12'd1000;

    // Dying: 60 frames, flap toggles ignored; btn left low for the last two rounds
    for (int k = 1; k <= 60; k++) begin
      btn_flap = (k % 2 == 0) && (k < 59);
      frame();
      chk("dying_state", 12'(state), (k < 60) ? 12'd2 : 12'd3);
      chk("dying_flap", 12'(flap_pulse), 12'd0);
      tick();
      chk("dying_flap2", 12'(flap_pulse), 12'd0);
      tick();
      chk("dying_flap3", 12'(flap_pulse), 12'd0);
    end
    chk("over_flag", 12'(game_over), 12'd1);
    chk("over_hi", hi_score_bcd, 12'h999);
    chk("over_score", score_bcd, 12'h999);

    // OVER -> IDLE on flap, never straight to PLAY
    btn_flap = 1'b1;
    tick(); tick(); tick();
    chk("over_to_idle", 12'(state), 12'd0);
    chk("idle_score_held", score_bcd, 12'h999);
    btn_flap = 1'b0;
    tick(); tick();
    btn_flap = 1'b1;
    tick(); tick(); tick();
    chk("g2_state", 12'(state), 12'd1);
    chk("g2_flap", 12'(flap_pulse), 12'd1);
    chk("g2_score", score_bcd, 12'h000);

    // Game 2: low score, ground boundary
    score_pulse = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    score_pulse = 1'b0;
    chk("g2_score5", score_bcd, 12'h005);
    bird_y = 12'd735;
    frame();
    chk("ground_735", 12'(collision), 12'd0);
    bird_y = 12'd736;
    frame();
    chk("ground_736", 12'(collision), 12'd1);
    chk("ground_state", 12'(state), 12'd2);
    bird_y = 12'd300;
    for (int k = 0; k < 60; k++) begin
      frame();
      tick();
    end
    chk("g2_over", 12'(state), 12'd3);
    chk("g2_hi_kept", hi_score_bcd, 12'h999);
    chk("g2_score_held", score_bcd, 12'h005);

    // Game 3: ceiling hit, then asynchronous reset while dying
    btn_flap = 1'b0;
    tick(); tick();
    btn_flap = 1'b1;
    tick(); tick(); tick();
    btn_flap = 1'b0;
    tick(); tick();
    btn_flap = 1'b1;
    tick(); tick(); tick();
    chk("g3_state", 12'(state), 12'd1);
    bird_y = 12'hFFE;
    frame();
    chk("ceil_coll", 12'(collision), 12'd1);
    chk("ceil_state", 12'(state), 12'd2);
    frame();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 12'(state), 12'd0);
    chk("arst_hi", hi_score_bcd, 12'h000);
    chk("arst_score", score_bcd, 12'h000);
    chk("arst_flags", {8'd0, game_active, game_over, flap_pulse, collision}, 12'd0);
    tick();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Top-level game state controller sitting directly downstream of the pipe generator. Each frame it consumes the pipe positions, gap centres and score pulses, together with the bird's vertical position. It detects bird/pipe/ground collisions, runs the IDLE/PLAY/DYING/OVER state machine, and keeps a 3-digit BCD score and high score. Its game_active output drives the pipe generator and bird physics upstream.

Parameters:
SCREEN_H, 768, visible height in pixels; ground line
BIRD_X, 300, fixed bird left-edge X
BIRD_SIZE, 32, bird bounding-box width and height
PIPE_W, 80, pipe width
PIPE_GAP_H, 220, gap height; half-gap = PIPE_GAP_H/2 = 110
DEATH_FRAMES, 60, frames spent in DYING before OVER

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_en  in  1  one-clk frame strobe
btn_flap  in  1  raw flap button level, asynchronous
bird_y  in  12  bird top-edge Y; values >= 2048 mean above the screen top (wrapped)
pipe1_x  in  12  pipe 1 left edge
pipe1_gap_y  in  12  pipe 1 gap centre
pipe2_x  in  12  pipe 2 left edge
pipe2_gap_y  in  12  pipe 2 gap centre
score_pulse  in  1  one-clk pass pulse from the pipe generator
game_active  out  1  high only in PLAY
game_over  out  1  high only in OVER
state  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3
flap_pulse  out  1  one-clk flap command to bird physics
collision  out  1  one-clk pulse on detected hit
score_bcd  out  12  {hundreds, tens, ones} BCD
hi_score_bcd  out  12  high score, BCD

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values: state=IDLE; all outputs 0; score and hi score 0; death counter 0; synchroniser flops 0.
- btn_flap input conditioning:
  - btn_flap passes through a 2-flop synchroniser, then a third flop for edge detection.
  - Rising edge = sync2 & ~sync3. Edge latency is 3 clks from the input change.
- IDLE:
  - Flap edge -> PLAY at the next clk edge.
  - Same edge: score cleared to 000, flap_pulse=1 for 1 clk.
- PLAY:
  - Flap edge -> flap_pulse for 1 clk.
  - score_pulse -> BCD increment with decimal carry. Saturate at 999.
  - On a frame_en cycle, evaluate collision from the inputs sampled that cycle. If hit: collision=1 for 1 clk and state<=DYING at that same edge.
- Collision terms (13-bit unsigned arithmetic, no wrap):
  - Ground: bird_y + BIRD_SIZE >= SCREEN_H.
  - Ceiling: bird_y[11] = 1.
  - Pipe n overlaps horizontally when pipe_x < BIRD_X + BIRD_SIZE AND pipe_x + PIPE_W > BIRD_X.
  - gap_top = gap_y - 110, clamped to 0 if gap_y < 110. gap_bot = gap_y + 110.
  - Pipe hit = horizontal overlap AND (bird_y < gap_top OR bird_y + BIRD_SIZE > gap_bot).
  - Edge contact is not a hit: bird_y == gap_top or bird_y + BIRD_SIZE == gap_bot.
- DYING:
  - Counter is cleared on entry and increments each frame_en.
  - When the counter reaches DEATH_FRAMES-1 on a frame_en -> OVER.
  - Flap edges and score_pulse are ignored.
- OVER entry edge: if score > hi score (BCD compare, hundreds digit first), hi score <= score. The hi score update and state change happen on the same edge.
- OVER: flap edge -> IDLE. Score is held so it stays displayed. Never goes directly to PLAY.
- Simultaneous events:
  - score_pulse and a hit on the same PLAY cycle: score increments and state goes to DYING.
  - Flap edge and a hit on the same cycle: flap_pulse still emitted.
- frame_en low: no collision evaluation and no death counting. Flap and score handling are unaffected by frame_en.
- hi_score_bcd survives every state change. It clears only on rst_n.
- Reset mid-operation: all state returns to reset values immediately, including the high score.

Optional Feature:
- Macro GAME_CTRL_GODMODE_EN.
- Defined: pipe-hit terms are forced to 0. Only ground and ceiling cause DYING, and score keeps accumulating while passing through pipes.
- Undefined: full collision set as above.
- Ports and state encoding are identical in both builds.

Test Plan:
1. Reset, then btn_flap rising edge -> 3 clks later state=1, game_active=1, flap_pulse single 1-clk pulse, score_bcd=0x000.
2. PLAY, bird_y=300, pipe1_x=250, pipe1_gap_y=384 (gap 274..494), frame_en -> no collision. Change bird_y=250 -> collision pulse, state=2 the next clk. With GODMODE_EN, no collision.
3. PLAY, 1000 score_pulses -> score_bcd steps through 0x009->0x010 and 0x099->0x100, stops at 0x999.
4. DYING, 60 frame_en strobes with btn_flap toggling -> no flap_pulse; state=3 after the 60th strobe; hi_score_bcd=score. A second game with a lower score leaves hi_score unchanged.
5. PLAY, bird_y=736 (736+32=768) -> collision on the next frame_en. bird_y=0xFFE -> ceiling collision.
6. rst_n low during DYING -> state=0, hi_score_bcd=0x000, all outputs 0 asynchronously.
